// File: rtl/pipe_stall_flush_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller:
// FSM state encoding, stall-bit polarity constants and the stall-bus width helper.
package pipe_stall_flush_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_FLUSH_WAIT = 2'd1,
    ST_FLUSH      = 2'd2
  } ctrl_state_e;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  // The stall bus carries one bit per pipeline stage plus bit 0 for the PC register.
  function automatic int stall_bus_w(input int nstage);
    return nstage + 1;
  endfunction

endpackage

// File: rtl/pipe_stall_flush_ctrl_if.sv
// Bundle of request/response signals between the pipeline and its stall/flush controller.
// The pipeline side uses the master modport, the controller uses the slave modport.
interface pipe_stall_flush_ctrl_if #(
  parameter int NSTAGE = 5,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 32
) ();

  logic [NSTAGE-1:0] stallreq;
  logic              flush_req;
  logic [PC_W-1:0]   flush_pc_i;
  logic [NSTAGE:0]   stall;
  logic              flush;
  logic [PC_W-1:0]   flush_pc;
  logic              flush_pending;
  logic              stall_timeout;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output stallreq, flush_req, flush_pc_i,
    input  stall, flush, flush_pc, flush_pending, stall_timeout, stall_cycles
  );

  modport slave (
    input  stallreq, flush_req, flush_pc_i,
    output stall, flush, flush_pc, flush_pending, stall_timeout, stall_cycles
  );

endinterface

// File: rtl/pipe_stall_flush_ctrl_stall_mask_enc.sv
// Priority encoder turning per-stage stall requests into a thermometer stall mask.
// The deepest requesting stage stalls itself and everything upstream, including the PC.
module stall_mask_enc
  import pipe_stall_flush_ctrl_pkg::*;
#(
  parameter int NSTAGE   = 5,
  parameter bit IF_AS_ID = 1'b1
) (
  input  logic [NSTAGE-1:0] stallreq,
  output logic [NSTAGE:0]   mask
);

  int k;

  // Find the deepest requesting stage, then fill the mask from bit 0 up to it.
  always_comb begin
    k = 0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (stallreq[i]) k = i + 1;
    end
    if (IF_AS_ID && k == 1) k = 2;
    mask = '0;
    for (int j = 0; j <= NSTAGE; j++) begin
      mask[j] = (k != 0 && j <= k) ? STOP : NOSTOP;
    end
  end

endmodule

// File: rtl/pipe_stall_flush_ctrl.sv
// Pipeline control unit: merges stall requests into the stall bus, sequences
// flushes that must wait behind memory-side stalls, and keeps stall statistics.
module pipe_stall_flush_ctrl
  import pipe_stall_flush_ctrl_pkg::*;
#(
  parameter int NSTAGE    = 5,
  parameter int MEM_STAGE = 4,
  parameter bit IF_AS_ID  = 1'b1,
  parameter int PC_W      = 32,
  parameter int CNT_W     = 32,
  parameter int TIMEOUT   = 1024
) (
  input logic                    cpu_clk_50M,
  input logic                    cpu_rst,
  pipe_stall_flush_ctrl_if.slave bus
);

  localparam int SW = stall_bus_w(NSTAGE);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CONSEC_MAX = CW'(TIMEOUT);

  ctrl_state_e     state_q, state_d;
  logic [PC_W-1:0] pend_pc_q, pend_pc_d;
  logic [PC_W-1:0] flush_pc_q, flush_pc_d;
  logic            flush_q, flush_d;
  logic            pending_q, pending_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [CW-1:0]   consec_q, consec_d;
  logic            timeout_q, timeout_d;

  logic [SW-1:0]   mask;
  logic [SW-1:0]   stall_c;
  logic            blk;

  stall_mask_enc #(
    .NSTAGE   (NSTAGE),
    .IF_AS_ID (IF_AS_ID)
  ) u_enc (
    .stallreq (bus.stallreq),
    .mask     (mask)
  );

  assign blk = |bus.stallreq[NSTAGE-1:MEM_STAGE-1];

  // The stall bus is released during reset and during the flush cycle so the flush can propagate.
  always_comb begin
    stall_c = mask;
    if (cpu_rst || state_q == ST_FLUSH) stall_c = '0;
  end

  // Flush sequencing: a request that meets a memory-side stall is parked until that stall drops.
  always_comb begin
    state_d    = state_q;
    pend_pc_d  = pend_pc_q;
    flush_pc_d = flush_pc_q;
    case (state_q)
      ST_RUN: begin
        if (bus.flush_req) begin
          if (blk) begin
            state_d   = ST_FLUSH_WAIT;
            pend_pc_d = bus.flush_pc_i;
          end else begin
            state_d    = ST_FLUSH;
            flush_pc_d = bus.flush_pc_i;
          end
        end
      end
      ST_FLUSH_WAIT: begin
        if (!blk) begin
          state_d    = ST_FLUSH;
          flush_pc_d = pend_pc_q;
        end
      end
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    flush_d   = (state_d == ST_FLUSH);
    pending_d = (state_d == ST_FLUSH_WAIT);
  end

  // Total and consecutive stall counters; both saturate rather than wrap.
  always_comb begin
    cycles_d  = cycles_q;
    consec_d  = '0;
    timeout_d = 1'b0;
    if (|stall_c) begin
      if (cycles_q != '1) cycles_d = cycles_q + CNT_W'(1);
      consec_d  = (consec_q == CONSEC_MAX) ? consec_q : consec_q + CW'(1);
      timeout_d = (consec_d == CONSEC_MAX);
    end
  end

  // State, latched PCs, registered outputs and counters.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_q    <= ST_RUN;
      pend_pc_q  <= '0;
      flush_pc_q <= '0;
      flush_q    <= 1'b0;
      pending_q  <= 1'b0;
      cycles_q   <= '0;
      consec_q   <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_pc_q  <= pend_pc_d;
      flush_pc_q <= flush_pc_d;
      flush_q    <= flush_d;
      pending_q  <= pending_d;
      cycles_q   <= cycles_d;
      consec_q   <= consec_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.stall         = stall_c;
  assign bus.flush         = flush_q;
  assign bus.flush_pc      = flush_pc_q;
  assign bus.flush_pending = pending_q;
  assign bus.stall_timeout = timeout_q;
  assign bus.stall_cycles  = cycles_q;

endmodule

// File: tb/tb_pipe_stall_flush_ctrl.sv
// Bench for pipe_stall_flush_ctrl: two instances (IF_AS_ID=1 and 0, short watchdog)
// share one stimulus stream and are compared against a flag-based reference model.
module tb_pipe_stall_flush_ctrl;

  localparam int T = 8;

  logic clk;
  logic rst;

  pipe_stall_flush_ctrl_if #(.NSTAGE(5), .PC_W(32), .CNT_W(32)) ifa ();
  pipe_stall_flush_ctrl_if #(.NSTAGE(5), .PC_W(32), .CNT_W(32)) ifb ();

  assign ifb.stallreq   = ifa.stallreq;
  assign ifb.flush_req  = ifa.flush_req;
  assign ifb.flush_pc_i = ifa.flush_pc_i;

  pipe_stall_flush_ctrl #(
    .NSTAGE(5), .MEM_STAGE(4), .IF_AS_ID(1'b1), .PC_W(32), .CNT_W(32), .TIMEOUT(T)
  ) dut_a (
    .cpu_clk_50M (clk),
    .cpu_rst     (rst),
    .bus         (ifa)
  );

  pipe_stall_flush_ctrl #(
    .NSTAGE(5), .MEM_STAGE(4), .IF_AS_ID(1'b0), .PC_W(32), .CNT_W(32), .TIMEOUT(T)
  ) dut_b (
    .cpu_clk_50M (clk),
    .cpu_rst     (rst),
    .bus         (ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model state, kept as plain flags and numbers.
  bit          m_flush;
  bit          m_pending;
  logic [31:0] m_pend_pc;
  logic [31:0] m_out_pc;
  logic [31:0] m_cycles;
  int          m_consec;
  bit          m_timeout;

  function automatic logic [5:0] ref_mask(input logic [4:0] sr, input bit if_as_id);
    int k;
    k = 0;
    for (int i = 0; i < 5; i++) if (sr[i]) k = i + 1;
    if (k == 1 && if_as_id) k = 2;
    if (k == 0) return 6'd0;
    return 6'((1 << (k + 1)) - 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check every output against the model, then advance the model.
  task automatic applyStimulus(input logic [4:0] sr, input bit fr, input logic [31:0] pc, input bit r);
    logic [5:0] exp_a, exp_b;
    bit blk;
    @(negedge clk);
    rst            = r;
    ifa.stallreq   = sr;
    ifa.flush_req  = fr;
    ifa.flush_pc_i = pc;
    #1;
    exp_a = (r || m_flush) ? 6'd0 : ref_mask(sr, 1'b1);
    exp_b = (r || m_flush) ? 6'd0 : ref_mask(sr, 1'b0);
    checkOutput("stall_a",   64'(ifa.stall),         64'(exp_a));
    checkOutput("stall_b",   64'(ifb.stall),         64'(exp_b));
    checkOutput("flush",     64'(ifa.flush),         64'(m_flush));
    checkOutput("flush_b",   64'(ifb.flush),         64'(m_flush));
    checkOutput("flush_pc",  64'(ifa.flush_pc),      64'(m_out_pc));
    checkOutput("pending",   64'(ifa.flush_pending), 64'(m_pending));
    checkOutput("timeout",   64'(ifa.stall_timeout), 64'(m_timeout));
    checkOutput("cycles",    64'(ifa.stall_cycles),  64'(m_cycles));

    blk = sr[4] | sr[3];
    if (r) begin
      m_flush = 0; m_pending = 0; m_pend_pc = '0; m_out_pc = '0;
      m_cycles = '0; m_consec = 0; m_timeout = 0;
    end else begin
      if (exp_a != 0) begin
        if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
        if (m_consec < T) m_consec = m_consec + 1;
        m_timeout = (m_consec == T);
      end else begin
        m_consec  = 0;
        m_timeout = 0;
      end
      if (m_flush) begin
        m_flush = 0;
      end else if (m_pending) begin
        if (!blk) begin
          m_pending = 0;
          m_flush   = 1;
          m_out_pc  = m_pend_pc;
        end
      end else if (fr) begin
        if (blk) begin
          m_pending = 1;
          m_pend_pc = pc;
        end else begin
          m_flush  = 1;
          m_out_pc = pc;
        end
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    ifa.stallreq   = '0;
    ifa.flush_req  = 1'b0;
    ifa.flush_pc_i = '0;
    m_flush = 0; m_pending = 0; m_pend_pc = '0; m_out_pc = '0;
    m_cycles = '0; m_consec = 0; m_timeout = 0;

    $display("[TB] reset");
    applyStimulus(5'b00000, 0, 32'h0, 1);
    applyStimulus(5'b00000, 0, 32'h0, 1);

    $display("[TB] stall mask patterns");
    applyStimulus(5'b00100, 0, 32'h0, 0);
    applyStimulus(5'b00000, 0, 32'h0, 0);
    applyStimulus(5'b00001, 0, 32'h0, 0);
    applyStimulus(5'b01010, 0, 32'h0, 0);
    applyStimulus(5'b10000, 0, 32'h0, 0);
    applyStimulus(5'b00000, 0, 32'h0, 0);

    $display("[TB] unblocked flush");
    applyStimulus(5'b00000, 1, 32'hBFC0_0380, 0);
    applyStimulus(5'b00110, 1, 32'h1111_2222, 0);
    applyStimulus(5'b00000, 0, 32'h0, 0);

    $display("[TB] flush waiting behind memory stall");
    applyStimulus(5'b01000, 1, 32'h1234_5678, 0);
    applyStimulus(5'b01000, 1, 32'h8000_0000, 0);
    applyStimulus(5'b01000, 0, 32'h0, 0);
    applyStimulus(5'b01000, 0, 32'h0, 0);
    applyStimulus(5'b00000, 0, 32'h0, 0);
    applyStimulus(5'b00000, 0, 32'h0, 0);
    applyStimulus(5'b00000, 0, 32'h0, 0);

    $display("[TB] stall watchdog");
    for (int i = 0; i < 10; i++) applyStimulus(5'b00100, 0, 32'h0, 0);
    applyStimulus(5'b00000, 0, 32'h0, 0);
    applyStimulus(5'b00000, 0, 32'h0, 0);

    $display("[TB] reset during flush wait");
    applyStimulus(5'b10000, 1, 32'hDEAD_BEEF, 0);
    applyStimulus(5'b10000, 0, 32'h0, 0);
    applyStimulus(5'b10000, 0, 32'h0, 1);
    applyStimulus(5'b00000, 0, 32'h0, 0);
    applyStimulus(5'b00000, 0, 32'h0, 0);
    applyStimulus(5'b00000, 0, 32'h0, 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      logic [4:0] sr;
      sr = 5'($urandom);
      if ($urandom_range(0, 2) == 0) sr = '0;
      if (i >= 200 && i < 215) sr = 5'b00010;
      applyStimulus(sr, ($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 63) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
